// File: rtl/pool_window_streamer.sv
// rtl/pool_window_streamer.sv - raster pixel stream to non-overlapping 2x2 windows
// One-row line buffer plus a single-entry output register with valid/ready.
module pool_window_streamer #(
  parameter int WIDTH = 32,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] x00,
  output logic [WIDTH-1:0] x01,
  output logic [WIDTH-1:0] x10,
  output logic [WIDTH-1:0] x11,
  output logic             win_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  typedef enum logic {TOP, BOT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] x00_q, x00_d, x01_q, x01_d, x10_q, x10_d, x11_q, x11_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;

  logic [WIDTH-1:0] linebuf [IMG_W];
  logic [CW-1:0]    col_m1;
  logic             accept;
  logic             col_wrap;
  logic             row_last;

  // Only the window-completing (odd) bottom-row pixel needs room in the output register.
  assign in_ready = (state_q == TOP) || !col_q[0] || !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);
  assign col_m1   = col_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_l_d    = hold_l_q;
    x00_d       = x00_q;
    x01_d       = x01_q;
    x10_d       = x10_q;
    x11_d       = x11_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end

    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        if (state_q == TOP) begin
          state_d = BOT;
          row_d   = row_q + RW'(1);
        end else begin
          state_d = TOP;
          row_d   = row_last ? '0 : row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end

      if (state_q == BOT) begin
        if (!col_q[0]) begin
          hold_l_d = in_data;
        end else begin
          x00_d       = linebuf[col_m1];
          x01_d       = linebuf[col_q];
          x10_d       = hold_l_q;
          x11_d       = in_data;
          win_valid_d = 1'b1;
          win_last_d  = row_last && col_wrap;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TOP;
      col_q       <= '0;
      row_q       <= '0;
      hold_l_q    <= '0;
      x00_q       <= '0;
      x01_q       <= '0;
      x10_q       <= '0;
      x11_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_l_q    <= hold_l_d;
      x00_q       <= x00_d;
      x01_q       <= x01_d;
      x10_q       <= x10_d;
      x11_q       <= x11_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  // Line buffer carries no reset; every entry is rewritten on each top row before use.
  always_ff @(posedge clk) begin
    if (accept && (state_q == TOP)) begin
      linebuf[col_q] <= in_data;
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign x00       = x00_q;
  assign x01       = x01_q;
  assign x10       = x10_q;
  assign x11       = x11_q;

endmodule

// File: tb/tb_pool_window_streamer.sv
// tb/tb_pool_window_streamer.sv - self-checking bench for pool_window_streamer
// 4x4 frames: table-driven frame check plus backpressure, bubble, reset and back-to-back sequences.
module tb_pool_window_streamer;

  localparam int WIDTH = 32;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             win_valid;
  logic             win_ready;
  logic [WIDTH-1:0] x00, x01, x10, x11;
  logic             win_last;

  pool_window_streamer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .x00(x00), .x01(x01), .x10(x10), .x11(x11),
    .win_last(win_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w00, w01, w10, w11;
    logic        last;
  } win_t;

  typedef struct {
    logic [31:0] din;
    logic        ev;
    logic [31:0] e00, e01, e10, e11;
    logic        el;
  } vec_t;

  win_t        got_q[$];
  int          stalls;
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_px [32];
  vec_t        vec [16];

  initial stalls = 0;

  // Record every window handshake and every stalled input cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid && win_ready) got_q.push_back('{x00, x01, x10, x11, win_last});
      if (in_valid && !in_ready) stalls++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Window j of frame f covers pixels tl, tl+1, tl+4, tl+5 of that frame.
  task automatic check_windows(input string nm, input int base, input int nframes);
    int n;
    n = got_q.size() - base;
    chk({nm, "_count"}, n, nframes * 4);
    for (int j = 0; j < nframes * 4 && j < n; j++) begin
      int f, w, tl;
      f  = j / 4;
      w  = j % 4;
      tl = f * 16 + (w / 2) * 8 + (w % 2) * 2;
      chk({nm, "_x00"}, got_q[base+j].w00, exp_px[tl]);
      chk({nm, "_x01"}, got_q[base+j].w01, exp_px[tl+1]);
      chk({nm, "_x10"}, got_q[base+j].w10, exp_px[tl+4]);
      chk({nm, "_x11"}, got_q[base+j].w11, exp_px[tl+5]);
      chk({nm, "_last"}, {31'd0, got_q[base+j].last}, {31'd0, (w == 3)});
    end
  endtask

  initial begin
    int base;
    int st0;
    n_checks = 0;
    n_fail   = 0;

    vec[0]  = '{0,  0, 0, 0, 0, 0, 0};
    vec[1]  = '{1,  0, 0, 0, 0, 0, 0};
    vec[2]  = '{2,  0, 0, 0, 0, 0, 0};
    vec[3]  = '{3,  0, 0, 0, 0, 0, 0};
    vec[4]  = '{4,  0, 0, 0, 0, 0, 0};
    vec[5]  = '{5,  1, 0, 1, 4, 5, 0};
    vec[6]  = '{6,  0, 0, 0, 0, 0, 0};
    vec[7]  = '{7,  1, 2, 3, 6, 7, 0};
    vec[8]  = '{8,  0, 0, 0, 0, 0, 0};
    vec[9]  = '{9,  0, 0, 0, 0, 0, 0};
    vec[10] = '{10, 0, 0, 0, 0, 0, 0};
    vec[11] = '{11, 0, 0, 0, 0, 0, 0};
    vec[12] = '{12, 0, 0, 0, 0, 0, 0};
    vec[13] = '{13, 1, 8, 9, 12, 13, 0};
    vec[14] = '{14, 0, 0, 0, 0, 0, 0};
    vec[15] = '{15, 1, 10, 11, 14, 15, 1};

    do_reset();
    chk("reset_win_valid", {31'd0, win_valid}, 32'd0);
    chk("reset_win_last", {31'd0, win_last}, 32'd0);
    chk("reset_x00", x00, 32'd0);
    chk("reset_x11", x11, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Frame 0..15 with full throughput, checked one cycle after each pixel.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i].din;
      @(negedge clk);
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("t1_win_valid", {31'd0, win_valid}, {31'd0, vec[i].ev});
      if (vec[i].ev) begin
        chk("t1_x00", x00, vec[i].e00);
        chk("t1_x01", x01, vec[i].e01);
        chk("t1_x10", x10, vec[i].e10);
        chk("t1_x11", x11, vec[i].e11);
        chk("t1_last", {31'd0, win_last}, {31'd0, vec[i].el});
      end
    end
    idle(2);

    // Backpressure on the first window.
    for (int k = 0; k < 16; k++) exp_px[k] = k;
    do_reset();
    base = got_q.size();
    for (int k = 0; k < 6; k++) send(k);
    win_ready = 1'b0;
    send(6);
    in_valid = 1'b1;
    in_data  = 7;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_win_valid", {31'd0, win_valid}, 32'd1);
      chk("bp_x00", x00, 32'd0);
      chk("bp_x01", x01, 32'd1);
      chk("bp_x10", x10, 32'd4);
      chk("bp_x11", x11, 32'd5);
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
    for (int k = 7; k < 16; k++) send(k);
    idle(3);
    check_windows("bp", base, 1);

    // Input bubbles with Q2.30 values.
    for (int k = 0; k < 16; k++) exp_px[k] = k * 32'h0400_0000;
    base = got_q.size();
    for (int k = 0; k < 16; k++) begin
      send(exp_px[k]);
      idle(1);
    end
    idle(2);
    check_windows("bubble", base, 1);

    // Reset after pixel 9 discards the partial frame.
    for (int k = 0; k < 10; k++) send(k);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("mrst_win_last", {31'd0, win_last}, 32'd0);
    chk("mrst_x00", x00, 32'd0);
    chk("mrst_x01", x01, 32'd0);
    chk("mrst_x10", x10, 32'd0);
    chk("mrst_x11", x11, 32'd0);
    for (int k = 0; k < 16; k++) exp_px[k] = 100 + k;
    base = got_q.size();
    for (int k = 0; k < 16; k++) send(exp_px[k]);
    idle(3);
    check_windows("mrst", base, 1);

    // Two frames with no gap; second frame uses 1.0 in Q2.30 plus an index.
    for (int k = 0; k < 16; k++) exp_px[k] = 200 + k;
    for (int k = 16; k < 32; k++) exp_px[k] = 32'h4000_0000 + k;
    base = got_q.size();
    st0  = stalls;
    for (int k = 0; k < 32; k++) send(exp_px[k]);
    idle(3);
    chk("b2b_stalls", stalls - st0, 32'd0);
    check_windows("b2b", base, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pool_window_streamer.md
Name: pool_window_streamer

Overview:
- Front-end feeder for the 2x2 pooling datapath (aad_pooling_2x2).
- Accepts a raster-scan pixel stream of one feature map in Q2.30 fixed point and buffers one row in a line buffer.
- Emits non-overlapping 2x2 windows (x00, x01, x10, x11) with a valid/ready handshake, ready to drive the pooler's four inputs directly.
- Sits between the feature-map source (DMA/previous layer) and the pooler.

Parameters:
- WIDTH, 32: pixel word width (Q2.30, FRAC_BITS = 30 applied upstream; block is format-agnostic).
- IMG_W, 8: pixels per row; must be even and >= 2.
- IMG_H, 8: rows per frame; must be even and >= 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept pixel.
- in_data  in  WIDTH  input pixel, raster order.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts window.
- x00  out  WIDTH  window top-left.
- x01  out  WIDTH  window top-right.
- x10  out  WIDTH  window bottom-left.
- x11  out  WIDTH  window bottom-right.
- win_last  out  1  qualifies the final window of a frame.

Behaviour:
- Reset (rst_n=0 at a clk edge): win_valid=0, win_last=0, x00..x11=0, col=0, row=0, state=TOP. Line buffer contents are not reset (don't care).
- Reset mid-frame discards the partial frame and any pending window. The next accepted pixel is row 0, col 0.
- Pixel transfer occurs on a cycle with in_valid && in_ready.
- col counts 0..IMG_W-1 and wraps to 0 at row end; row increments on col wrap.
- FSM states:
  - TOP (even row): each accepted pixel is written to linebuf[col]. No output. When col wraps, go to BOT.
  - BOT (odd row), even col: accepted pixel is held in register hold_l.
  - BOT, odd col: accepted pixel forms a window and loads the output register:
    - x00 = linebuf[col-1]
    - x01 = linebuf[col]
    - x10 = hold_l
    - x11 = in_data
    - win_valid <= 1
    - win_last <= 1 iff row == IMG_H-1 and col == IMG_W-1
  - BOT, when col wraps: if row == IMG_H-1, set row=0 and go to TOP (frame end); otherwise row++ and go to TOP.
- Latency: window is visible one cycle after the handshake of its x11 pixel.
- in_ready:
  - 1 in TOP and on BOT even columns.
  - On BOT odd columns: 1 iff !win_valid || win_ready (single-entry output register, drained in the same cycle).
  - Never depends combinationally on in_valid.
- Output register:
  - Cleared (win_valid -> 0) on win_valid && win_ready unless reloaded in the same cycle.
  - Simultaneous drain and load: new window is loaded and win_valid stays 1.
  - While win_valid && !win_ready, x00..x11 and win_last hold stable.
- Throughput: with in_valid and win_ready held at 1, one pixel per cycle, no bubbles, one window per 2 odd-row pixels.
- Back-to-back frames: the first pixel of frame N+1 is accepted in the cycle after the last pixel of frame N; the last window of frame N may still be pending.
- Widths: data is passed through unmodified; no arithmetic on pixel values.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H), minimum 1 bit.

Test Plan:
- Frame content (IMG_W=4, IMG_H=4, pixels 0..15, in_valid=1, win_ready=1): expect
  - (0,1,4,5)
  - (2,3,6,7)
  - (8,9,12,13)
  - (10,11,14,15) with win_last=1
  - Windows appear 1 cycle after pixels 5, 7, 13, 15 respectively; in_ready stays 1 throughout.
- Backpressure: same frame with win_ready=0 from the first window until 5 cycles later.
  - Window (0,1,4,5) holds stable.
  - in_ready drops when pixel 7 is presented.
  - After release, windows arrive in order with none lost or duplicated.
- Input bubbles: in_valid toggles 1,0,1,0 over a Q2.30 frame with p = k*0x04000000 (0.0625*k). Windows match the first test's pixel mapping with these values, and only win_last changes per frame.
- Reset mid-frame: assert rst_n=0 for 1 cycle after pixel 9.
  - Next cycle: win_valid=0, outputs 0.
  - A new full frame 100..115 yields (100,101,104,105) ... (110,111,114,115).
- Back-to-back frames: two frames sent with no gap. Exactly 8 windows result, with win_last asserted on windows 4 and 8 only, and no stall cycles on in_ready.
- Protocol integration: drive x00..x11 into aad_pooling_2x2 with 1.0 = 0x40000000 inputs. Pooler input pairs match the window contents on every win_valid && win_ready cycle.
